// File: rtl/puf_challenge_ctrl.sv
// Challenge/response sequencer for the dual-adder PDL PUF core: launches one race per challenge
// and packs synchronised responses into RESP_BITS words. Optional macro: PUF_MAJORITY_VOTE_EN.
module puf_challenge_ctrl #(
    parameter int CFG_W         = 128,
    parameter int RESP_BITS     = 32,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 chal_valid,
    output logic                 chal_ready,
    input  logic [CFG_W-1:0]     chal_cfg1,
    input  logic [CFG_W-1:0]     chal_cfg2,
    output logic [CFG_W-1:0]     puf_config1,
    output logic [CFG_W-1:0]     puf_config2,
    output logic                 puf_a,
    output logic                 puf_b,
    input  logic                 puf_c,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [RESP_BITS-1:0] resp_data,
    output logic                 busy
);
    localparam int CNT_W = $clog2(RESP_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_FIRE, S_SETTLE, S_SAMPLE, S_OUT
    } state_t;

    state_t                 r_state, w_next;
    logic [7:0]             r_timer;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [RESP_BITS-1:0]   r_shift;
    logic [CFG_W-1:0]       r_cfg1, r_cfg2;
    logic                   r_sync1, r_sync2;
    logic                   w_timer_done;
    logic                   w_last_bit;
    logic                   w_last_run;
    logic                   w_bit;

    assign w_timer_done = (r_timer == 8'(SETTLE_CYCLES - 1));
    assign w_last_bit   = (r_bit_cnt == CNT_W'(RESP_BITS - 1));

`ifdef PUF_MAJORITY_VOTE_EN
    logic [1:0] r_run;
    logic [1:0] r_ones;
    logic [2:0] w_votes;

    assign w_votes    = 3'(r_ones) + 3'(r_sync2);
    assign w_last_run = (r_run == 2'd2);
    assign w_bit      = (w_votes >= 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run  <= 2'd0;
            r_ones <= 2'd0;
        end else if (r_state == S_SAMPLE) begin
            if (w_last_run) begin
                r_run  <= 2'd0;
                r_ones <= 2'd0;
            end else begin
                r_run  <= r_run + 2'd1;
                r_ones <= r_ones + 2'(r_sync2);
            end
        end
    end
`else
    assign w_last_run = 1'b1;
    assign w_bit      = r_sync2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (chal_valid) w_next = S_ARM;
            S_ARM:    if (w_timer_done) w_next = S_FIRE;
            S_FIRE:   w_next = S_SETTLE;
            S_SETTLE: if (w_timer_done) w_next = S_SAMPLE;
            S_SAMPLE: begin
                if (!w_last_run)     w_next = S_ARM;
                else if (w_last_bit) w_next = S_OUT;
                else                 w_next = S_IDLE;
            end
            S_OUT:    if (resp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Shared dwell timer for ARM and SETTLE; cleared on every other state and on expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_timer <= 8'd0;
        else if ((r_state == S_ARM || r_state == S_SETTLE) && !w_timer_done)
            r_timer <= r_timer + 8'd1;
        else
            r_timer <= 8'd0;
    end

    // puf_c is asynchronous to clk; only r_sync2 is ever consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= puf_c;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg1    <= '0;
            r_cfg2    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            if (r_state == S_IDLE && chal_valid) begin
                r_cfg1 <= chal_cfg1;
                r_cfg2 <= chal_cfg2;
            end
            if (r_state == S_SAMPLE && w_last_run) begin
                r_shift   <= r_shift | (RESP_BITS'(w_bit) << r_bit_cnt);
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end else if (r_state == S_OUT && resp_ready) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end
        end
    end

    assign chal_ready  = (r_state == S_IDLE) && rst_n;
    assign puf_config1 = r_cfg1;
    assign puf_config2 = r_cfg2;
    assign puf_a       = (r_state == S_FIRE) || (r_state == S_SETTLE);
    assign puf_b       = puf_a;
    assign resp_valid  = (r_state == S_OUT);
    assign resp_data   = r_shift;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_puf_challenge_ctrl.sv
// Self-checking bench for puf_challenge_ctrl with a response-word scoreboard.
module tb_puf_challenge_ctrl;
    localparam int CFG_W = 128;
    localparam int RB    = 32;
    localparam int SC    = 16;
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int RUNS = 3;
`else
    localparam int RUNS = 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             chal_valid = 1'b0;
    logic             chal_ready;
    logic [CFG_W-1:0] chal_cfg1 = '0;
    logic [CFG_W-1:0] chal_cfg2 = '0;
    logic [CFG_W-1:0] puf_config1, puf_config2;
    logic             puf_a, puf_b;
    logic             puf_c = 1'b0;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic [RB-1:0]    resp_data;
    logic             busy;

    puf_challenge_ctrl #(.CFG_W(CFG_W), .RESP_BITS(RB), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n),
        .chal_valid(chal_valid), .chal_ready(chal_ready),
        .chal_cfg1(chal_cfg1), .chal_cfg2(chal_cfg2),
        .puf_config1(puf_config1), .puf_config2(puf_config2),
        .puf_a(puf_a), .puf_b(puf_b), .puf_c(puf_c),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [RB-1:0] exp_q[$];
    logic [RB-1:0] exp_word = '0;
    int            exp_cnt = 0;
    logic [RB-1:0] held_word = '0;
    logic [CFG_W-1:0] last_cfg1 = '0;
    logic [CFG_W-1:0] last_cfg2 = '0;

    task automatic model_bit(input logic b);
        exp_word[exp_cnt] = b;
        exp_cnt++;
        if (exp_cnt == RB) begin
            exp_q.push_back(exp_word);
            exp_word = '0;
            exp_cnt  = 0;
        end
    endtask

    task automatic send_chal(input logic [CFG_W-1:0] c1, input logic [CFG_W-1:0] c2,
                             input logic v0, input logic v1, input logic v2);
        int   rises = 0;
        int   guard = 0;
        logic prev_a;
        logic maj;
        @(negedge clk);
        puf_c = v0; chal_cfg1 = c1; chal_cfg2 = c2; chal_valid = 1'b1;
        while (!chal_ready && guard < 50) begin @(negedge clk); guard++; end
        n_cmp++;
        if (!chal_ready) begin
            n_err++; $display("FAIL send_ready: chal_ready=%b required 1", chal_ready);
        end
        @(posedge clk);
        @(negedge clk);
        chal_valid = 1'b0;
        last_cfg1 = c1; last_cfg2 = c2;
        n_cmp++;
        if (puf_config1 !== c1 || puf_config2 !== c2) begin
            n_err++; $display("FAIL cfg_load: got %h/%h required %h/%h", puf_config1, puf_config2, c1, c2);
        end
        prev_a = puf_a;
        guard  = 0;
        while (!(chal_ready || resp_valid) && guard < 400) begin
            @(negedge clk);
            guard++;
            if (puf_a && !prev_a) begin
                rises++;
                if (rises == 2) puf_c = v1;
                if (rises == 3) puf_c = v2;
            end
            prev_a = puf_a;
        end
        n_cmp++;
        if (rises !== RUNS || guard >= 400) begin
            n_err++; $display("FAIL race_count: rises=%0d guard=%0d required %0d rises", rises, guard, RUNS);
        end
        maj = (int'(v0) + int'(v1) + int'(v2)) >= 2;
        model_bit(RUNS == 1 ? v0 : maj);
    endtask

    task automatic check_word();
        logic [RB-1:0] e;
        n_cmp++;
        if (resp_valid !== 1'b1) begin
            n_err++; $display("FAIL word_valid: resp_valid=%b required 1", resp_valid);
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++; $display("FAIL word_queue: no expected word, got %h", resp_data);
        end else begin
            e = exp_q.pop_front();
            held_word = e;
            if (resp_data !== e) begin
                n_err++; $display("FAIL word_data: got %h required %h", resp_data, e);
            end
        end
    endtask

    task automatic accept_word();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        n_cmp++;
        if (resp_valid !== 1'b0 || chal_ready !== 1'b1 || resp_data !== '0) begin
            n_err++; $display("FAIL accept: valid=%b ready=%b data=%h required 0/1/0", resp_valid, chal_ready, resp_data);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; chal_valid = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (chal_ready !== 1'b0 || puf_a !== 1'b0 || puf_b !== 1'b0 || resp_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_ctrl: ready=%b a=%b b=%b valid=%b required 0", chal_ready, puf_a, puf_b, resp_valid);
        end
        n_cmp++;
        if (resp_data !== '0 || puf_config1 !== '0 || puf_config2 !== '0 || busy !== 1'b0) begin
            n_err++; $display("FAIL reset_data: data=%h cfg1=%h busy=%b required 0", resp_data, puf_config1, busy);
        end
        chal_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (chal_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_release: chal_ready=%b required 1", chal_ready);
        end
    endtask

    task automatic test_timing();
        int first_a = 0;
        int first_rdy = 0;
        logic [CFG_W-1:0] c1 = {4{32'hC0FF_EE01}};
        logic [CFG_W-1:0] c2 = {4{32'h1234_5678}};
        @(negedge clk);
        puf_c = 1'b0; chal_cfg1 = c1; chal_cfg2 = c2; chal_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 130 && first_rdy == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chal_valid = 1'b0;
                n_cmp++;
                if (puf_config1 !== c1 || puf_config2 !== c2 || busy !== 1'b1) begin
                    n_err++; $display("FAIL timing_cfg: cfg1=%h busy=%b required %h/1", puf_config1, busy, c1);
                end
            end
            if (puf_a && first_a == 0) first_a = k;
            if (chal_ready && first_rdy == 0) first_rdy = k;
        end
        last_cfg1 = c1; last_cfg2 = c2;
        n_cmp++;
        if (first_a !== SC + 1) begin
            n_err++; $display("FAIL timing_fire: puf_a rose at T+%0d required T+%0d", first_a, SC + 1);
        end
        n_cmp++;
        if (first_rdy !== 1 + RUNS * (2 * SC + 2)) begin
            n_err++; $display("FAIL timing_ready: ready at T+%0d required T+%0d", first_rdy, 1 + RUNS * (2 * SC + 2));
        end
        model_bit(1'b0);
    endtask

    task automatic test_packing();
        for (int i = 1; i < RB; i++) begin
            logic b;
            b = i[0];
            send_chal({4{32'(i)}}, ~{4{32'(i)}}, b, b, b);
        end
        check_word();
    endtask

    task automatic test_back_pressure();
        @(negedge clk);
        chal_cfg1 = {4{32'hDEAD_BEEF}}; chal_cfg2 = {4{32'hFEED_FACE}}; chal_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_cmp++;
            if (resp_data !== held_word || chal_ready !== 1'b0 || resp_valid !== 1'b1 || puf_config1 !== last_cfg1) begin
                n_err++; $display("FAIL backpressure: data=%h ready=%b valid=%b cfg1=%h required %h/0/1/%h",
                                  resp_data, chal_ready, resp_valid, puf_config1, held_word, last_cfg1);
            end
        end
        chal_valid = 1'b0;
        accept_word();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || puf_config2 !== last_cfg2) begin
            n_err++; $display("FAIL accept_once: valid=%b busy=%b cfg2=%h required 0/0/%h", resp_valid, busy, puf_config2, last_cfg2);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 4; i++) send_chal({4{32'(i + 100)}}, '0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        puf_c = 1'b1; chal_cfg1 = '1; chal_cfg2 = '1; chal_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chal_valid = 1'b0;
        repeat (SC + 4) @(negedge clk);
        n_cmp++;
        if (puf_a !== 1'b1) begin
            n_err++; $display("FAIL midrst_settle: puf_a=%b required 1", puf_a);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (puf_a !== 1'b0 || puf_b !== 1'b0 || puf_config1 !== '0 || resp_valid !== 1'b0 ||
            resp_data !== '0 || chal_ready !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL midrst_outputs: a=%b cfg1=%h valid=%b data=%h ready=%b busy=%b required all 0",
                              puf_a, puf_config1, resp_valid, resp_data, chal_ready, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_word = '0; exp_cnt = 0;
        for (int i = 0; i < RB; i++) send_chal({4{32'(i + 7)}}, {4{32'(i)}}, (i % 3) == 2, (i % 3) == 2, (i % 3) == 2);
        check_word();
        accept_word();
    endtask

`ifdef PUF_MAJORITY_VOTE_EN
    task automatic test_majority();
        for (int i = 0; i < RB; i++) begin
            case (i % 4)
                0:       send_chal({4{32'(i)}}, '0, 1'b1, 1'b0, 1'b1);
                1:       send_chal({4{32'(i)}}, '0, 1'b0, 1'b0, 1'b1);
                2:       send_chal({4{32'(i)}}, '0, 1'b0, 1'b1, 1'b1);
                default: send_chal({4{32'(i)}}, '0, 1'b1, 1'b0, 1'b0);
            endcase
        end
        check_word();
        accept_word();
    endtask
`endif

    initial begin
        test_reset();
        test_timing();
        test_packing();
        test_back_pressure();
        test_mid_reset();
`ifdef PUF_MAJORITY_VOTE_EN
        test_majority();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
